// File: rtl/debug_buffer_tx.sv
// Debug-buffer byte serializer: snapshots an N-bit buffer on start and feeds it LSB byte first to a UART TX core.
// Optional macro DBG_SYNC_HEADER_EN prepends a SYNC_BYTE header transfer to every frame.
module debug_buffer_tx #(
  parameter int N      = 1184,
  parameter int NBYTES = N / 8,
  parameter int CW     = 8
`ifdef DBG_SYNC_HEADER_EN
  , parameter logic [7:0] SYNC_BYTE = 8'hA5
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] buffer_envio,
  input  logic         tx_done_tick,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         done_tick,
  output logic [2:0]   dbg_state
);

  // Handshake: tx_start is a one-cycle load strobe; tx_data is held until the core
  // answers with a one-cycle tx_done_tick, and only ticks seen while waiting count.

  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3
`ifdef DBG_SYNC_HEADER_EN
    , S_HDR      = 3'd4,
    S_HDR_WAIT = 3'd5
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   snap_q, snap_d;
  logic [IW-1:0]  bit_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    tx_start  = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = buffer_envio;
          cnt_d   = '0;
`ifdef DBG_SYNC_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_SEND;
`endif
        end
      end
      S_SEND: begin
        tx_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_DONE: begin
        done_tick = 1'b1;
        state_d   = S_IDLE;
      end
`ifdef DBG_SYNC_HEADER_EN
      S_HDR: begin
        tx_start = 1'b1;
        state_d  = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        if (tx_done_tick) state_d = S_SEND;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Reset must never let a load strobe or completion pulse escape in its own cycle.
    if (reset) begin
      tx_start  = 1'b0;
      done_tick = 1'b0;
    end
  end

  assign bit_idx = IW'({cnt_q, 3'b000});

  always_comb begin
    tx_data = snap_q[bit_idx +: 8];
`ifdef DBG_SYNC_HEADER_EN
    if (state_q == S_HDR || state_q == S_HDR_WAIT) tx_data = SYNC_BYTE;
`endif
  end

  assign busy      = (state_q != S_IDLE) && !reset;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_debug_buffer_tx.sv
// Self-checking bench for debug_buffer_tx: UART TX model with fixed done latency and a byte scoreboard.
`timescale 1ns/1ps
module tb_debug_buffer_tx;

  localparam int N        = 1184;
  localparam int NBYTES   = N / 8;
  localparam int TX_DELAY = 10;
`ifdef DBG_SYNC_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FRAME        = NBYTES + HDR;
  localparam int FRAME_BUDGET = FRAME * (TX_DELAY + 4) + 100;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] buffer_envio;
  logic         tx_done_tick = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         busy;
  logic         done_tick;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_b;
  logic [7:0] cur_byte;
  int  n_start = 0, n_done = 0, cyc = 0, last_tick_cyc = 0, done_cyc = 0;
  int  delay_cnt = 0;
  bit  pending = 1'b0;
  bit  inject_same = 1'b0, inject_idle = 1'b0;

  debug_buffer_tx dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .buffer_envio (buffer_envio),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .done_tick    (done_tick),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // UART TX model and scoreboard, sampling 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    tx_done_tick = 1'b0;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (done_tick) begin
        n_done++;
        done_cyc = cyc;
      end
      if (tx_start) begin
        n_start++;
        sent_q.push_back(tx_data);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_byte: unexpected tx_start, tx_data=%02h, none expected", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b)
            $display("FAIL sb_byte #%0d: tx_data=%02h expected=%02h", n_start - 1, tx_data, exp_b);
          else
            n_pass++;
        end
        cur_byte  = tx_data;
        pending   = 1'b1;
        delay_cnt = TX_DELAY;
        if (inject_same) begin
          tx_done_tick = 1'b1;
          inject_same  = 1'b0;
        end
      end else if (pending) begin
        delay_cnt--;
        if (delay_cnt == 0) begin
          n_checks++;
          if (tx_data !== cur_byte)
            $display("FAIL tx_data_hold: tx_data=%02h expected=%02h", tx_data, cur_byte);
          else
            n_pass++;
          tx_done_tick  = 1'b1;
          pending       = 1'b0;
          last_tick_cyc = cyc;
        end
      end else if (inject_idle) begin
        tx_done_tick = 1'b1;
        inject_idle  = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic fill_random();
    for (int i = 0; i < NBYTES; i++) buffer_envio[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  // Call at a negedge; returns at the negedge of the cycle after the start is sampled.
  task automatic send_start();
    if (HDR != 0) exp_q.push_back(8'hA5);
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(buffer_envio[8*i +: 8]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    buffer_envio = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_start, busy, done_tick, tx_data} !== 11'h000)
        $display("FAIL reset_idle cyc%0d: tx_start=%b busy=%b done_tick=%b tx_data=%02h expected 0/0/0/00",
                 i, tx_start, busy, done_tick, tx_data);
      else n_pass++;
    end
    n_checks++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: dbg_state=%0d expected 0", dbg_state);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    bit ok;
    int s0, base;
    logic [7:0] lit [5];
    lit = '{8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    fill_random();
    buffer_envio[7:0]     = 8'h12;
    buffer_envio[39:8]    = 32'hDEADBEEF;
    buffer_envio[N-1:N-8] = 8'h03;
    s0   = n_start;
    base = sent_q.size();
    send_start();
    n_checks++;
    if (tx_start !== 1'b1) $display("FAIL start_latency: tx_start=%b expected 1", tx_start);
    else n_pass++;
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL full_done_timeout: done_tick=0 expected 1 within budget");
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_at_done: busy=%b expected 1", busy);
    else n_pass++;
    n_checks++;
    if (done_cyc !== last_tick_cyc + 1)
      $display("FAIL done_latency: done_cyc=%0d expected %0d", done_cyc, last_tick_cyc + 1);
    else n_pass++;
    n_checks++;
    if (n_start - s0 !== FRAME) $display("FAIL full_count: tx_start pulses=%0d expected %0d", n_start - s0, FRAME);
    else n_pass++;
    if (sent_q.size() >= base + FRAME) begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (sent_q[base + HDR + i] !== lit[i])
          $display("FAIL full_byte%0d: got %02h expected %02h", i, sent_q[base + HDR + i], lit[i]);
        else n_pass++;
      end
      n_checks++;
      if (sent_q[base + HDR + NBYTES - 1] !== 8'h03)
        $display("FAIL full_last_byte: got %02h expected 03", sent_q[base + HDR + NBYTES - 1]);
      else n_pass++;
      if (HDR != 0) begin
        n_checks++;
        if (sent_q[base] !== 8'hA5) $display("FAIL header_byte: got %02h expected a5", sent_q[base]);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done_tick} !== 2'b00) $display("FAIL busy_drop: busy=%b done_tick=%b expected 0/0", busy, done_tick);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL full_sb_empty: %0d bytes left, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_snapshot();
    bit ok;
    int s0;
    fill_random();
    s0 = n_start;
    send_start();
    repeat (30) @(negedge clk);
    buffer_envio = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL snap_done_timeout: done_tick=0 expected 1 within budget");
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_start - s0 !== FRAME) $display("FAIL snap_count: tx_start pulses=%0d expected %0d", n_start - s0, FRAME);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL snap_no_second_frame: busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_spurious();
    bit ok;
    int s0;
    inject_idle = 1'b1;
    repeat (5) @(negedge clk);
    s0 = n_start;
    n_checks++;
    if ({busy, tx_start} !== 2'b00) $display("FAIL idle_tick: busy=%b tx_start=%b expected 0/0", busy, tx_start);
    else n_pass++;
    fill_random();
    inject_same = 1'b1;
    send_start();
    repeat (300) @(negedge clk);
    inject_same = 1'b1;
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL spur_done_timeout: done_tick=0 expected 1 within budget");
    else n_pass++;
    n_checks++;
    if (n_start - s0 !== FRAME) $display("FAIL spur_count: tx_start pulses=%0d expected %0d", n_start - s0, FRAME);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL spur_sb_empty: %0d bytes left, expected 0", exp_q.size());
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    int s0, d0, base;
    fill_random();
    s0 = n_start;
    d0 = n_done;
    send_start();
    hit = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      if (n_start - s0 == HDR + 51) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) $display("FAIL reach_byte50: tx_start pulses=%0d expected %0d", n_start - s0, HDR + 51);
    else n_pass++;
    // Now in the SEND cycle of byte 50.
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx_start !== 1'b0) $display("FAIL reset_in_send: tx_start=%b expected 0", tx_start);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, tx_start, done_tick} !== 3'b000)
      $display("FAIL reset_abort: busy=%b tx_start=%b done_tick=%b expected 0/0/0", busy, tx_start, done_tick);
    else n_pass++;
    reset = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    n_checks++;
    if (n_done !== d0 || n_start - s0 !== HDR + 51)
      $display("FAIL reset_quiet: done_ticks=%0d starts=%0d expected %0d/%0d", n_done - d0, n_start - s0, 0, HDR + 51);
    else n_pass++;
    fill_random();
    s0   = n_start;
    base = sent_q.size();
    send_start();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL restart_done_timeout: done_tick=0 expected 1 within budget");
    else n_pass++;
    n_checks++;
    if (n_start - s0 !== FRAME) $display("FAIL restart_count: tx_start pulses=%0d expected %0d", n_start - s0, FRAME);
    else n_pass++;
    if (sent_q.size() > base + HDR) begin
      n_checks++;
      if (sent_q[base + HDR] !== buffer_envio[7:0])
        $display("FAIL restart_byte0: got %02h expected %02h", sent_q[base + HDR], buffer_envio[7:0]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s0;
    fill_random();
    s0 = n_start;
    send_start();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_done_timeout: done_tick=0 expected 1 within budget");
    else n_pass++;
    // A start in the DONE cycle is dropped; one in the very next cycle is accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL start_in_done_dropped: busy=%b expected 0", busy);
    else n_pass++;
    fill_random();
    send_start();
    n_checks++;
    if (tx_start !== 1'b1) $display("FAIL b2b_latency: tx_start=%b expected 1", tx_start);
    else n_pass++;
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL b2b2_done_timeout: done_tick=0 expected 1 within budget");
    else n_pass++;
    n_checks++;
    if (n_start - s0 !== 2 * FRAME) $display("FAIL b2b_count: tx_start pulses=%0d expected %0d", n_start - s0, 2 * FRAME);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    buffer_envio = '0;
    test_reset();
    test_full_frame();
    test_snapshot();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_buffer_tx.md
Name: debug_buffer_tx

Overview:
- Byte serializer for the debugger link.
- On a start request it snapshots the packed N-bit debug buffer and streams it byte by byte to the UART transmitter through a start/done handshake.
- Byte 0 is buffer bits [7:0]; bytes go out LSB-first, ending with the byte at bits [N-1:N-8].
- Sits between the debug packing logic and the UART TX core.

Parameters:
- N, 1184, width of the packed debug buffer in bits; must be a multiple of 8.
- NBYTES, N/8 (148), number of payload bytes sent per frame.
- CW, 8, byte counter width; must satisfy 2^CW >= NBYTES+1.
- SYNC_BYTE, 8'hA5, header value, used only when DBG_SYNC_HEADER_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send a frame; sampled only in IDLE.
- buffer_envio  input  N  packed debug state; captured on the accepted start.
- tx_done_tick  input  1  one-cycle pulse from the UART TX core when the current byte is fully sent.
- tx_start  output  1  one-cycle pulse telling the UART TX core to load tx_data.
- tx_data  output  8  byte to transmit; stable from the tx_start cycle until tx_done_tick.
- busy  output  1  high from the cycle after an accepted start until done_tick inclusive.
- done_tick  output  1  one-cycle pulse after the last byte's tx_done_tick.

Behaviour:
- Reset (synchronous, high) outputs:
  - tx_start=0, tx_data=8'h00, busy=0, done_tick=0.
  - Byte counter = 0, snapshot register = 0, state = IDLE.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - On start=1: latch buffer_envio into the snapshot, set counter=0, go to SEND.
  - All other inputs are ignored, including tx_done_tick.
- SEND (one cycle):
  - tx_data = snapshot byte[counter]; tx_start=1 for this cycle only; go to WAIT.
- WAIT:
  - tx_start=0; hold tx_data.
  - On tx_done_tick=1: if counter==NBYTES-1, go to DONE; else counter+1 and go to SEND.
  - A tx_done_tick in the same cycle as tx_start (SEND state) is ignored. Only ticks seen in WAIT count.
- DONE (one cycle): done_tick=1, busy=1; next state IDLE.
- Latency:
  - Accepted start to first tx_start: 1 cycle.
  - tx_done_tick to the next tx_start: 1 cycle.
  - Last tx_done_tick to done_tick: 1 cycle.
- Snapshot isolation: changes on buffer_envio while busy do not affect the frame in progress.
- start while busy (SEND/WAIT/DONE) is dropped, not queued. A start arriving in the cycle after DONE is accepted normally.
- Counter never exceeds NBYTES-1 during a frame and returns to 0 only on the next accepted start or on reset.
- tx_data is indexed as snapshot[8*counter +: 8].
- Reset in any state aborts the frame immediately, with no partial done_tick. If reset lands in SEND, tx_start is forced to 0 that cycle.
- The UART core is assumed to ignore loads while it is busy; this block never issues tx_start while in WAIT.

Optional Feature:
- Macro: DBG_SYNC_HEADER_EN.
- Defined:
  - Adds state HDR between IDLE and the first SEND.
  - HDR drives tx_data=SYNC_BYTE and pulses tx_start, then waits for tx_done_tick like WAIT.
  - Payload then proceeds from counter=0.
  - Frame length is NBYTES+1 transfers; accepted start to the header tx_start is 1 cycle.
- Not defined:
  - No HDR state; the frame is exactly NBYTES payload bytes.
  - SYNC_BYTE is unused.

Test Plan:
1. Reset then idle: hold reset 3 cycles, release, no start -> tx_start, busy and done_tick stay 0; tx_data=00 for 20 cycles.
2. Full frame: buffer_envio[7:0]=8'h12, [39:8]=32'hDEADBEEF, [1183:1176]=8'h03, start pulse, TX model returns tx_done_tick 10 cycles after each tx_start -> exactly 148 tx_start pulses. Bytes 0..4 = 12,EF,BE,AD,DE; byte 147 = 03. done_tick 1 cycle after the 148th done; busy drops the following cycle.
3. Snapshot/ignore: during the frame, change buffer_envio to all-ones and pulse start twice -> transmitted bytes still match the original snapshot; no second frame starts.
4. Spurious done: assert tx_done_tick in IDLE and in the same cycle as a tx_start -> counter unchanged, no extra tx_start, frame still 148 bytes.
5. Reset mid-frame: assert reset after byte 50's tx_start -> next cycle busy=0, tx_start=0, no done_tick. A new start sends from byte 0 again.
6. With DBG_SYNC_HEADER_EN: start pulse -> first tx_data=A5, followed by 148 payload bytes (149 tx_start total); done_tick after the 149th tx_done_tick.
